// File: rtl/hit_pair_gen.sv
// hit_pair_gen: burst generator of TDC start/stop hit pairs.
// A start in IDLE latches the configuration, waits delay1 cycles, then emits
// hit1/hit2 pulse pairs spaced p_eff cycles apart until count pairs have been
// produced (count=0: until abort). done pulses once at the end of a burst.
// Optional feature: define HIT_PAIR_GEN_PRBS_EN to add a 16-bit LFSR jitter
// term (lfsr[3:0]) to delay2 for every pair.
module hit_pair_gen #(
    parameter int CNT_W = 16,
    parameter int PW_W  = 4
) (
    input  logic             ckref,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay1,
    input  logic [CNT_W-1:0] delay2,
    input  logic [CNT_W-1:0] period,
    input  logic [PW_W-1:0]  width,
    input  logic [CNT_W-1:0] count,
    output logic             hit1,
    output logic             hit2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_cnt
);

    // Wide enough for delay2 + jitter + pulse width + 1 without overflow.
    localparam int EW = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT1, RUN, FINISH} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] delay2;
        logic [CNT_W-1:0] period;
        logic [PW_W-1:0]  width;
        logic [CNT_W-1:0] count;
    } cfg_t;

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] phase_q, phase_d;     // cycles since the current hit1 rise
    logic [CNT_W:0]   d2e_q, d2e_d;         // effective hit1->hit2 offset of this pair
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic             hit1_q, hit1_d;
    logic             hit2_q, hit2_d;
`ifdef HIT_PAIR_GEN_PRBS_EN
    logic [15:0]      lfsr_q, lfsr_d;
`endif

    logic             accept;
    logic             rise;
    logic             eval;
    logic [CNT_W-1:0] phase_inc;
    logic [CNT_W-1:0] phase_n;
    logic [CNT_W-1:0] pair_base;
    logic [CNT_W:0]   d2e_new;
    logic [EW-1:0]    w_eff;
    logic [EW-1:0]    p_min;
    logic [EW-1:0]    p_eff;
    logic [EW-1:0]    hit2_end;

    // Abort wins over start; the config is taken from the ports on the accepting edge.
    assign accept    = (state_q == IDLE) && start && !abort;
    assign cfg_d     = accept ? {delay2, period, width, count} : cfg_q;
    assign w_eff     = (cfg_d.width == '0) ? EW'(1) : EW'(cfg_d.width);
    assign phase_inc = (phase_q == '1) ? phase_q : phase_q + CNT_W'(1);
    assign p_min     = EW'(d2e_q) + w_eff + EW'(1);
    assign p_eff     = (EW'(cfg_d.period) > p_min) ? EW'(cfg_d.period) : p_min;
    assign hit2_end  = EW'(d2e_q) + w_eff;
`ifdef HIT_PAIR_GEN_PRBS_EN
    assign d2e_new   = {1'b0, cfg_d.delay2} + (CNT_W+1)'(lfsr_q[3:0]);
`else
    assign d2e_new   = {1'b0, cfg_d.delay2};
`endif

    // Next-state, pair timing and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        wait_d     = wait_q;
        phase_d    = phase_q;
        d2e_d      = d2e_q;
        pair_cnt_d = pair_cnt_q;
        hit1_d     = 1'b0;
        hit2_d     = 1'b0;
        rise       = 1'b0;
        eval       = 1'b0;
        phase_n    = phase_q;
        pair_base  = pair_cnt_q;
`ifdef HIT_PAIR_GEN_PRBS_EN
        lfsr_d     = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pair_base  = '0;
                    pair_cnt_d = '0;
                    if (delay1 == '0) begin
                        rise    = 1'b1;
                        state_d = RUN;
                    end else begin
                        wait_d  = delay1;
                        state_d = WAIT1;
                    end
                end
            end
            WAIT1: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wait_q <= CNT_W'(1)) begin
                    rise    = 1'b1;
                    state_d = RUN;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_q.count != '0 && pair_cnt_q >= cfg_q.count &&
                             EW'(phase_inc) >= hit2_end) begin
                    state_d = FINISH;
                end else if (EW'(phase_inc) >= p_eff || phase_q == '1) begin
                    rise = 1'b1;
                end else begin
                    phase_n = phase_inc;
                    eval    = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rise) begin
            eval    = 1'b1;
            phase_n = '0;
            d2e_d   = d2e_new;
`ifdef HIT_PAIR_GEN_PRBS_EN
            lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
        end

        if (eval) begin
            phase_d = phase_n;
            hit1_d  = EW'(phase_n) < w_eff;
            hit2_d  = (EW'(phase_n) >= EW'(d2e_d)) && (EW'(phase_n) < EW'(d2e_d) + w_eff);
            if ({1'b0, phase_n} == d2e_d && pair_base != '1) begin
                pair_cnt_d = pair_base + CNT_W'(1);
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge ckref or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            wait_q     <= '0;
            phase_q    <= '0;
            d2e_q      <= '0;
            pair_cnt_q <= '0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
`ifdef HIT_PAIR_GEN_PRBS_EN
            lfsr_q     <= 16'hACE1;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            wait_q     <= wait_d;
            phase_q    <= phase_d;
            d2e_q      <= d2e_d;
            pair_cnt_q <= pair_cnt_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
`ifdef HIT_PAIR_GEN_PRBS_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign hit1     = hit1_q;
    assign hit2     = hit2_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_hit_pair_gen.sv
// tb_hit_pair_gen: directed bursts; expected edge events are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT produces them.
module tb_hit_pair_gen;

    localparam int CNT_W = 16;
    localparam int PW_W  = 4;

    logic             ckref = 1'b0;
    logic             rst, start, abort;
    logic [CNT_W-1:0] delay1, delay2, period, count;
    logic [PW_W-1:0]  width;
    logic             hit1, hit2, busy, done;
    logic [CNT_W-1:0] pair_cnt;

    hit_pair_gen #(.CNT_W(CNT_W), .PW_W(PW_W)) dut (
        .ckref(ckref), .rst(rst), .start(start), .abort(abort),
        .delay1(delay1), .delay2(delay2), .period(period), .width(width), .count(count),
        .hit1(hit1), .hit2(hit2), .busy(busy), .done(done), .pair_cnt(pair_cnt)
    );

    always #5 ckref = ~ckref;

    int cyc = 0;
    always @(posedge ckref) cyc <= cyc + 1;

    typedef enum int {K_H1R, K_H1F, K_H2R, K_H2F, K_DONE} kind_t;
    typedef struct {
        kind_t kind;
        int    cyc;
        int    pc;
    } ev_t;

    ev_t  exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
`ifdef HIT_PAIR_GEN_PRBS_EN
    logic [15:0] ref_lfsr = 16'hACE1;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input kind_t k, input int c, input int pc);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic match(input kind_t k);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == k) idx = i;
        end
        if (idx < 0) begin
            check({"unexpected_", k.name()}, cyc, -1);
        end else begin
            check({k.name(), "_cycle"}, cyc, exp_q[idx].cyc);
            if (k == K_H2R) check("pair_cnt_at_hit2", pair_cnt, exp_q[idx].pc);
            if (k == K_DONE) check("busy_during_done", busy, 1);
            exp_q.delete(idx);
        end
    endtask

    // Monitor: turn output edges into events and compare against the queue.
    always @(negedge ckref) begin
        if (mon_en) begin
            if (hit1 && !p1) match(K_H1R);
            if (!hit1 && p1) match(K_H1F);
            if (hit2 && !p2) match(K_H2R);
            if (!hit2 && p2) match(K_H2F);
            if (done)        match(K_DONE);
        end
        p1 <= hit1;
        p2 <= hit2;
    end

    // Expected events for npairs pairs of a burst accepted in cycle t.
    task automatic push_pairs(input int t, input int d1, input int d2, input int p, input int w,
                              input int npairs, input bit with_done, input bit cut_last,
                              output int last_r, output int last_d2);
        int weff = (w == 0) ? 1 : w;
        int r    = t + 1 + d1;
        int d2e, peff;
        last_r  = r;
        last_d2 = d2;
        for (int k = 0; k < npairs; k++) begin
            d2e = d2;
`ifdef HIT_PAIR_GEN_PRBS_EN
            d2e      = d2 + int'(ref_lfsr[3:0]);
            ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
`endif
            peff = (p > d2e + weff + 1) ? p : d2e + weff + 1;
            push(K_H1R, r, 0);
            push(K_H1F, r + weff, 0);
            push(K_H2R, r + d2e, k + 1);
            if (!(cut_last && k == npairs - 1)) push(K_H2F, r + d2e + weff, 0);
            if (with_done && k == npairs - 1) push(K_DONE, r + d2e + weff, 0);
            last_r  = r;
            last_d2 = d2e;
            r += peff;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic do_start(input int d1, input int d2, input int p, input int w, input int c,
                            output int t);
        delay1 = CNT_W'(d1);
        delay2 = CNT_W'(d2);
        period = CNT_W'(p);
        width  = PW_W'(w);
        count  = CNT_W'(c);
        start  = 1'b1;
        t      = cyc;
        @(posedge ckref); #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(posedge ckref); #1;
            n++;
        end
        check({name, "_idle"}, busy, 0);
        check({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target && g < 5000) begin
            @(posedge ckref); #1;
            g++;
        end
        check("reach_cycle", cyc, target);
    endtask

    task automatic run_burst(input string name, input int d1, input int d2, input int p,
                             input int w, input int c);
        int t, lr, ld;
        do_start(d1, d2, p, w, c, t);
        push_pairs(t, d1, d2, p, w, c, 1'b1, 1'b0, lr, ld);
        wait_idle(name, 2000);
        check({name, "_pair_cnt"}, pair_cnt, c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t, lr, ld, ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        delay1 = '0; delay2 = '0; period = '0; width = '0; count = '0;

        #12;
        check("rst_hit1", hit1, 0);
        check("rst_hit2", hit2, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        @(posedge ckref); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge ckref); #1;

        // Four pairs: hit1 at T+4, +24, +44, +64; hit2 five cycles later.
        run_burst("burst_4pairs", 3, 5, 20, 2, 4);
        // Coincident single-cycle hit1/hit2, one pair.
        run_burst("coincident", 2, 0, 10, 0, 1);
        // delay1=0: hit1 in the cycle right after start; period below the minimum.
        run_burst("no_delay1", 0, 1, 0, 1, 2);
        // period=3 widened to delay2+w_eff+1 = 8.
        run_burst("min_spacing", 1, 5, 3, 2, 3);

        // Continuous burst aborted while the 10th hit2 is high; a start mid-burst is ignored.
        do_start(2, 3, 12, 3, 0, t);
        push_pairs(t, 2, 3, 12, 3, 10, 1'b0, 1'b1, lr, ld);
        wait_cyc(t + 30);
        delay1 = '0; count = CNT_W'(1); width = '0;
        start  = 1'b1;
        @(posedge ckref); #1;
        start  = 1'b0;
        ab = lr + ld + 1;
        wait_cyc(ab);
        abort = 1'b1;
        push(K_H2F, ab + 1, 0);
        @(posedge ckref); #1;
        abort = 1'b0;
        check("abort_hit1", hit1, 0);
        check("abort_hit2", hit2, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pair_cnt", pair_cnt, 10);
        repeat (20) @(posedge ckref);
        #1;
        check("abort_pending_events", exp_q.size(), 0);
        check("abort_pair_cnt_held", pair_cnt, 10);

        // Abort and start together in IDLE: nothing starts, pair_cnt kept.
        start = 1'b1; abort = 1'b1;
        @(posedge ckref); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        repeat (5) @(posedge ckref);
        #1;
        check("abort_start_busy_later", busy, 0);
        check("abort_start_pair_cnt", pair_cnt, 10);

        // Asynchronous reset in the middle of overlapping hit1/hit2 pulses.
        mon_en = 1'b0;
        do_start(1, 2, 6, 3, 0, t);
        begin
            int g = 0;
            while (!(hit2 === 1'b1 && pair_cnt == 2) && g < 200) begin
                @(negedge ckref);
                g++;
            end
            check("reach_second_hit2", pair_cnt, 2);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hit1", hit1, 0);
        check("async_rst_hit2", hit2, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_pair_cnt", pair_cnt, 0);
        @(posedge ckref); #1;
        rst = 1'b0;
        exp_q.delete();
`ifdef HIT_PAIR_GEN_PRBS_EN
        ref_lfsr = 16'hACE1;
`endif
        repeat (8) @(posedge ckref);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_hit1", hit1, 0);
        mon_en = 1'b1;

        // A fresh start works after reset.
        run_burst("after_reset", 0, 0, 0, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
